mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Two-port arbiter in front of a single-port synchronous RAM. The data port
//   normally wins. The instruction port gets priority once it has been denied
//   STARVE_MAX cycles in a row. Reads have a fixed one-cycle latency, and read
//   data is steered back to the port that issued the read. A halt input drains
//   any outstanding read and then parks the arbiter until halt is released.
//
// Ports
//   clk, reset                 clock, asynchronous active-low reset
//   halt                       stop issuing grants (RUN -> DRAIN -> HALTED)
//   i_req, i_addr              instruction-fetch read request
//   i_gnt, i_rvalid, i_rdata   instruction grant / read return
//   d_req, d_we, d_addr,
//   d_wdata                    data-port request (read or write)
//   d_gnt, d_rvalid, d_rdata   data grant / read return
//   ram_en, ram_we, ram_addr,
//   ram_wdata, ram_rdata       RAM side; ram_rdata valid one cycle after a read
//   busy                       read in flight, or arbiter not in RUN
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int AW         = 9,
    parameter int DW         = 16,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          halt,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          busy
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIMIT = SW'(STARVE_MAX);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

    state_t        state;
    owner_t        rd_owner;
    logic [SW-1:0] starve_cnt;

    logic can_grant;
    logic i_wins;

    // Grants are also gated by reset so that every output reads 0 while
    // reset is held, not only after the next clock edge.
    assign can_grant = reset && (state == RUN) && !halt;
    assign i_wins    = i_req && (starve_cnt == STARVE_LIMIT);
    assign d_gnt     = can_grant && d_req && !i_wins;
    assign i_gnt     = can_grant && i_req && !d_gnt;

    // Return path: rd_owner records which port the RAM data belongs to.
    assign i_rvalid = (rd_owner == OWN_I);
    assign d_rvalid = (rd_owner == OWN_D);
    assign i_rdata  = i_rvalid ? ram_rdata : '0;
    assign d_rdata  = d_rvalid ? ram_rdata : '0;
    assign busy     = (rd_owner != OWN_NONE) || (state != RUN);

    // NOTE: every signal driven from always_comb gets a default value first,
    // so no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (i_gnt) begin
            ram_en    = 1'b1;
            ram_addr  = i_addr;
            ram_wdata = d_wdata;
        end else if (d_gnt) begin
            ram_en    = 1'b1;
            ram_we    = d_we;
            ram_addr  = d_addr;
            ram_wdata = d_wdata;
        end
    end

    // NOTE: state registers use non-blocking assignments only, so every
    // register samples values from before the edge regardless of the order
    // of the statements below.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= RUN;
            rd_owner   <= OWN_NONE;
            starve_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (halt) begin
                        state <= (rd_owner != OWN_NONE) ? DRAIN : HALTED;
                    end
                end
                DRAIN: begin
                    if (rd_owner == OWN_NONE) begin
                        state <= HALTED;
                    end
                end
                HALTED: begin
                    if (!halt) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase

            // Writes and idle cycles leave nothing in flight.
            if (i_gnt) begin
                rd_owner <= OWN_I;
            end else if (d_gnt && !d_we) begin
                rd_owner <= OWN_D;
            end else begin
                rd_owner <= OWN_NONE;
            end

            // The starvation count only moves on cycles where arbitration
            // actually happens. It holds while draining or halted.
            if (can_grant) begin
                if (i_gnt || !i_req) begin
                    starve_cnt <= '0;
                end else if (starve_cnt != STARVE_LIMIT) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int AW = 9;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          halt;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;
    logic          busy;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(3)) dut (
        .clk(clk), .reset(reset), .halt(halt),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // RAM model: word a initially holds 0x1000 + a. The array stores the
    // difference from that pattern, so a zero initializer suffices.
    logic [DW-1:0] mem_delta [512] = '{default: '0};

    function automatic logic [DW-1:0] base_val(input logic [AW-1:0] a);
        return 16'h1000 + {7'b0, a};
    endfunction

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem_delta[ram_addr] <= ram_wdata ^ base_val(ram_addr);
            else        ram_rdata <= mem_delta[ram_addr] ^ base_val(ram_addr);
        end
    end

    // Packed view of all outputs:
    // {i_gnt,d_gnt,i_rvalid,i_rdata,d_rvalid,d_rdata,ram_en,ram_we,ram_addr,ram_wdata,busy}
    logic [63:0] outs;
    assign outs = {i_gnt, d_gnt, i_rvalid, i_rdata, d_rvalid, d_rdata,
                   ram_en, ram_we, ram_addr, ram_wdata, busy};

    function automatic logic [63:0] o(
        input logic ig, input logic dg,
        input logic iv, input logic [15:0] ird,
        input logic dv, input logic [15:0] drd,
        input logic en, input logic we,
        input logic [8:0] addr, input logic [15:0] wd,
        input logic bsy);
        return {ig, dg, iv, ird, dv, drd, en, we, addr, wd, bsy};
    endfunction

    typedef struct {
        logic          halt;
        logic          i_req;
        logic [AW-1:0] i_addr;
        logic          d_req;
        logic          d_we;
        logic [AW-1:0] d_addr;
        logic [DW-1:0] d_wdata;
        logic [63:0]   exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic h, input logic ir, input logic [8:0] ia,
                       input logic dr, input logic dw, input logic [8:0] da,
                       input logic [15:0] dwd, input logic [63:0] e);
        vec_t v;
        v.halt = h; v.i_req = ir; v.i_addr = ia;
        v.d_req = dr; v.d_we = dw; v.d_addr = da; v.d_wdata = dwd;
        v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] exp);
        total++;
        if (outs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, outs, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        @(negedge clk);
        halt = v.halt; i_req = v.i_req; i_addr = v.i_addr;
        d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata;
        #1;
        check(name, v.exp);
    endtask

    task automatic drive_idle();
        halt = 0; i_req = 0; i_addr = '0; d_req = 0; d_we = 0;
        d_addr = '0; d_wdata = '0;
    endtask

    function automatic vec_t mkv(input logic h, input logic ir, input logic [8:0] ia,
                                 input logic dr, input logic [8:0] da,
                                 input logic [63:0] e);
        vec_t v;
        v.halt = h; v.i_req = ir; v.i_addr = ia;
        v.d_req = dr; v.d_we = 1'b0; v.d_addr = da; v.d_wdata = '0;
        v.exp = e;
        return v;
    endfunction

    initial begin
        // Both ports request continuously: three data grants, then one instruction grant.
        add(0,1,9'h010,1,0,9'h020,0, o(0,1,0,0,0,0,1,0,9'h020,0,0));
        add(0,1,9'h010,1,0,9'h020,0, o(0,1,0,0,1,16'h1020,1,0,9'h020,0,1));
        add(0,1,9'h010,1,0,9'h020,0, o(0,1,0,0,1,16'h1020,1,0,9'h020,0,1));
        add(0,1,9'h010,1,0,9'h020,0, o(1,0,0,0,1,16'h1020,1,0,9'h010,0,1));
        add(0,1,9'h010,1,0,9'h020,0, o(0,1,1,16'h1010,0,0,1,0,9'h020,0,1));
        add(0,1,9'h010,1,0,9'h020,0, o(0,1,0,0,1,16'h1020,1,0,9'h020,0,1));
        add(0,1,9'h010,1,0,9'h020,0, o(0,1,0,0,1,16'h1020,1,0,9'h020,0,1));
        add(0,1,9'h010,1,0,9'h020,0, o(1,0,0,0,1,16'h1020,1,0,9'h010,0,1));
        add(0,0,0,0,0,0,0,           o(0,0,1,16'h1010,0,0,0,0,0,0,1));
        add(0,0,0,0,0,0,0,           o(0,0,0,0,0,0,0,0,0,0,0));
        // Write 0xBEEF to 0x055, then read it back on the data port.
        add(0,0,0,1,1,9'h055,16'hBEEF, o(0,1,0,0,0,0,1,1,9'h055,16'hBEEF,0));
        add(0,0,0,1,0,9'h055,0,        o(0,1,0,0,0,0,1,0,9'h055,0,0));
        add(0,0,0,0,0,0,0,             o(0,0,0,0,1,16'hBEEF,0,0,0,0,1));
        add(0,0,0,0,0,0,0,             o(0,0,0,0,0,0,0,0,0,0,0));
        // Instruction-only stream over addresses 0..7.
        for (int k = 0; k < 8; k++) begin
            add(0,1,9'(k),0,0,0,0,
                o(1,0,k>0,(k>0) ? base_val(9'(k-1)) : 16'h0,0,0,1,0,9'(k),0,k>0));
        end
        add(0,0,0,0,0,0,0, o(0,0,1,16'h1007,0,0,0,0,0,0,1));
        // Halt right after an instruction grant: DRAIN, HALTED, then resume.
        add(0,1,9'h030,0,0,0,0,         o(1,0,0,0,0,0,1,0,9'h030,0,0));
        add(1,0,0,0,0,0,0,              o(0,0,1,16'h1030,0,0,0,0,0,0,1));
        add(1,0,0,0,0,0,0,              o(0,0,0,0,0,0,0,0,0,0,1));
        add(1,1,9'h010,1,0,9'h020,0,    o(0,0,0,0,0,0,0,0,0,0,1));
        add(0,1,9'h010,1,0,9'h020,0,    o(0,0,0,0,0,0,0,0,0,0,1));
        add(0,0,0,1,0,9'h020,0,         o(0,1,0,0,0,0,1,0,9'h020,0,0));
        // Starvation count is held across a 10-cycle halt with i_req high.
        add(0,1,9'h010,1,0,9'h020,0,    o(0,1,0,0,1,16'h1020,1,0,9'h020,0,1));
        add(0,1,9'h010,1,0,9'h020,0,    o(0,1,0,0,1,16'h1020,1,0,9'h020,0,1));
        add(1,1,9'h010,0,0,0,0,         o(0,0,0,0,1,16'h1020,0,0,0,0,1));
        for (int k = 0; k < 9; k++) begin
            add(1,1,9'h010,0,0,0,0,     o(0,0,0,0,0,0,0,0,0,0,1));
        end
        add(0,1,9'h010,0,0,0,0,         o(0,0,0,0,0,0,0,0,0,0,1));
        add(0,1,9'h010,1,0,9'h020,0,    o(0,1,0,0,0,0,1,0,9'h020,0,0));
        add(0,1,9'h010,1,0,9'h020,0,    o(1,0,0,0,1,16'h1020,1,0,9'h010,0,1));

        // Reset held with requests asserted: every output must be 0.
        reset = 0;
        halt = 0; i_req = 1; i_addr = 9'h010; d_req = 1; d_we = 0;
        d_addr = 9'h020; d_wdata = 16'h1234;
        repeat (2) @(negedge clk);
        #1 check("reset_hold", 64'h0);
        drive_idle();
        @(negedge clk);
        reset = 1;

        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

        // Reset asserted between a read grant and its rvalid.
        apply(mkv(0,1,9'h010,1,9'h020, o(0,1,1,16'h1010,0,0,1,0,9'h020,0,1)), "pre_rst0");
        apply(mkv(0,1,9'h010,1,9'h020, o(0,1,0,0,1,16'h1020,1,0,9'h020,0,1)), "pre_rst1");
        #2 reset = 0;
        #1 check("rst_async", 64'h0);
        @(negedge clk);
        drive_idle();
        reset = 1;
        #1 check("rst_release", 64'h0);
        // A cleared starvation count gives three data grants before the instruction grant.
        apply(mkv(0,1,9'h010,1,9'h020, o(0,1,0,0,0,0,1,0,9'h020,0,0)), "post_rst0");
        apply(mkv(0,1,9'h010,1,9'h020, o(0,1,0,0,1,16'h1020,1,0,9'h020,0,1)), "post_rst1");
        apply(mkv(0,1,9'h010,1,9'h020, o(0,1,0,0,1,16'h1020,1,0,9'h020,0,1)), "post_rst2");
        apply(mkv(0,1,9'h010,1,9'h020, o(1,0,0,0,1,16'h1020,1,0,9'h010,0,1)), "post_rst3");

        @(negedge clk);
        drive_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
